// File: rtl/synth_regs_pkg.sv
// Shared constants and helpers for the synthesizer register file.
// Register indices, I2C field positions and the default data width live here.
package synth_regs_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int REG_I2C      = 6;
    localparam int REG_PWM_BASE = 8;
    localparam int I2C_ADDR_LSB = 0;
    localparam int I2C_STS_LSB  = 9;

    // Index width for n entries; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/synth_reg_file_p_rd_port.sv
// One combinational read port: index decode, zero/out-of-range handling and
// same-cycle write forwarding.
module reg_rd_port
    import synth_regs_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic [NUM_REGS*DATA_W-1:0] regs,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          fwd_data,
    output logic [DATA_W-1:0]          rd_data
);

    logic hit;

    assign hit = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);

    // Indices with no matching entry fall through to zero.
    always_comb begin
        rd_data = '0;
        if (rd_addr != '0) begin
            if (hit) begin
                rd_data = fwd_data;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (rd_addr == ADDR_W'(i)) rd_data = regs[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/synth_reg_file_p.sv
// Parametrised N-read/1-write register file with hardwired r0, I2C control/status
// register (sticky W1C bits, start strobe) and double-buffered PWM channels.
module synth_reg_file_p
    import synth_regs_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_REGS   = 16,
    parameter int NUM_RD     = 3,
    parameter int BYPASS     = 1,
    parameter int I2C_REG    = REG_I2C,
    parameter int I2C_ADDR_W = I2C_STS_LSB - I2C_ADDR_LSB,
    parameter int STS_W      = 2,
    parameter int PWM_BASE   = REG_PWM_BASE,
    parameter int NUM_PWM    = 8,
    localparam int ADDR_W    = clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic [STS_W-1:0]           i2c_sts,
    output logic [I2C_ADDR_W-1:0]      i2c_addr,
    output logic                       i2c_go,
    input  logic                       pwm_commit,
    output logic [NUM_PWM*DATA_W-1:0]  pwm_out
);

    if (I2C_REG < 1 || I2C_REG >= NUM_REGS) begin : g_bad_i2c_reg
        $error("synth_reg_file_p: I2C_REG out of range");
    end
    if (PWM_BASE < 1 || PWM_BASE + NUM_PWM > NUM_REGS) begin : g_bad_pwm_range
        $error("synth_reg_file_p: PWM register range out of bounds");
    end
    if (I2C_REG >= PWM_BASE && I2C_REG < PWM_BASE + NUM_PWM) begin : g_bad_overlap
        $error("synth_reg_file_p: I2C_REG overlaps PWM registers");
    end
    if (I2C_ADDR_W + STS_W > DATA_W) begin : g_bad_i2c_fields
        $error("synth_reg_file_p: I2C fields wider than DATA_W");
    end

    logic [DATA_W-1:0]          mem [NUM_REGS];
    logic [STS_W-1:0]           sts_q;
    logic                       wr_ok;
    logic                       wr_i2c;
    logic [DATA_W-1:0]          i2c_word;
    logic [DATA_W-1:0]          fwd_data;
    logic [NUM_REGS*DATA_W-1:0] view_flat;

    assign wr_ok    = write_en && (wr_addr != '0) &&
                      ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_REGS));
    assign wr_i2c   = wr_ok && (wr_addr == ADDR_W'(I2C_REG));
    assign i2c_word = DATA_W'({sts_q, i2c_addr});

    // Forwarding into the I2C register only carries the software field; the
    // sticky bits always come from storage.
    assign fwd_data = (wr_addr == ADDR_W'(I2C_REG)) ?
                      DATA_W'({sts_q, wr_data[I2C_ADDR_W-1:0]}) : wr_data;

    always_comb begin
        view_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            view_flat[i*DATA_W +: DATA_W] = (i == I2C_REG) ? i2c_word : mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (i != I2C_REG && wr_ok && wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
            end
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i2c_addr <= '0;
            sts_q    <= '0;
            i2c_go   <= 1'b0;
        end else begin
            i2c_go <= wr_i2c;
            if (wr_i2c) i2c_addr <= wr_data[I2C_ADDR_W-1:0];
            for (int j = 0; j < STS_W; j++) begin
                if (i2c_sts[j]) sts_q[j] <= 1'b1;
                else if (wr_i2c && wr_data[I2C_ADDR_W+j]) sts_q[j] <= 1'b0;
            end
        end
    end

    // Commit samples staging before any same-edge write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= '0;
        end else if (pwm_commit) begin
            for (int c = 0; c < NUM_PWM; c++) begin
                pwm_out[c*DATA_W +: DATA_W] <= mem[PWM_BASE+c];
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        reg_rd_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
            .regs     (view_flat),
            .wr_en    (wr_ok),
            .wr_addr  (wr_addr),
            .fwd_data (fwd_data),
            .rd_data  (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_synth_reg_file_p.sv
// Directed bench for synth_reg_file_p with a bypassing and a non-bypassing instance.
module tb_synth_reg_file_p;

    logic         clk;
    logic         rst;
    logic         write_en;
    logic [3:0]   wr_addr;
    logic [15:0]  wr_data;
    logic [11:0]  rd_addr;
    logic [47:0]  rd_data, rd_data_nb;
    logic [1:0]   i2c_sts;
    logic [8:0]   i2c_addr, i2c_addr_nb;
    logic         i2c_go, i2c_go_nb;
    logic         pwm_commit;
    logic [127:0] pwm_out, pwm_out_nb;

    int total = 0;
    int bad   = 0;

    synth_reg_file_p dut (
        .clk(clk), .rst(rst), .write_en(write_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .i2c_sts(i2c_sts), .i2c_addr(i2c_addr),
        .i2c_go(i2c_go), .pwm_commit(pwm_commit), .pwm_out(pwm_out)
    );

    synth_reg_file_p #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .write_en(write_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .i2c_sts(i2c_sts), .i2c_addr(i2c_addr_nb),
        .i2c_go(i2c_go_nb), .pwm_commit(pwm_commit), .pwm_out(pwm_out_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; write_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; i2c_sts = '0; pwm_commit = 1'b0;
        #3;
        total++; if (rd_data !== 48'h0) begin bad++; $display("FAIL init_rd got=%h exp=0", rd_data); end
        total++; if (pwm_out !== 128'h0) begin bad++; $display("FAIL init_pwm got=%h exp=0", pwm_out); end
        total++; if (i2c_go !== 1'b0) begin bad++; $display("FAIL init_go got=%b exp=0", i2c_go); end
        total++; if (i2c_addr !== 9'h0) begin bad++; $display("FAIL init_addr got=%h exp=0", i2c_addr); end
        tick(); tick();
        rst = 1'b1;
        tick();
        write_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; tick();
        wr_addr = 4'd8; wr_data = 16'h00AA; tick();
        wr_addr = 4'd6; wr_data = 16'h0011; pwm_commit = 1'b1; tick();
        write_en = 1'b0; pwm_commit = 1'b0; rd_addr = {3{4'd3}};
        #1;
        total++; if (rd_data[15:0] !== 16'h1234) begin bad++; $display("FAIL pre_rst_r3 got=%h exp=1234", rd_data[15:0]); end
        total++; if (i2c_go !== 1'b1) begin bad++; $display("FAIL pre_rst_go got=%b exp=1", i2c_go); end
        total++; if (pwm_out[15:0] !== 16'h00AA) begin bad++; $display("FAIL pre_rst_ch0 got=%h exp=00aa", pwm_out[15:0]); end
        rst = 1'b0;
        #1;
        total++; if (rd_data !== 48'h0) begin bad++; $display("FAIL async_rst_rd got=%h exp=0", rd_data); end
        total++; if (pwm_out !== 128'h0) begin bad++; $display("FAIL async_rst_pwm got=%h exp=0", pwm_out); end
        total++; if (i2c_go !== 1'b0) begin bad++; $display("FAIL async_rst_go got=%b exp=0", i2c_go); end
        total++; if (i2c_addr !== 9'h0) begin bad++; $display("FAIL async_rst_addr got=%h exp=0", i2c_addr); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_r0();
        rd_addr = {3{4'd0}};
        write_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        #1;
        total++; if (rd_data !== 48'h0) begin bad++; $display("FAIL r0_during_write got=%h exp=0", rd_data); end
        tick();
        write_en = 1'b0;
        #1;
        total++; if (rd_data !== 48'h0) begin bad++; $display("FAIL r0_after_write got=%h exp=0", rd_data); end
    endtask

    task automatic test_bypass();
        rd_addr = {3{4'd5}};
        write_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rd_data[k*16 +: 16] !== 16'hBEEF) begin
                bad++; $display("FAIL bypass_port%0d got=%h exp=beef", k, rd_data[k*16 +: 16]);
            end
            total++;
            if (rd_data_nb[k*16 +: 16] !== 16'h0000) begin
                bad++; $display("FAIL nobypass_old_port%0d got=%h exp=0000", k, rd_data_nb[k*16 +: 16]);
            end
        end
        tick();
        write_en = 1'b0;
        #1;
        total++; if (rd_data !== {3{16'hBEEF}}) begin bad++; $display("FAIL bypass_stored got=%h exp=beef x3", rd_data); end
        total++; if (rd_data_nb !== {3{16'hBEEF}}) begin bad++; $display("FAIL nobypass_next got=%h exp=beef x3", rd_data_nb); end
    endtask

    task automatic test_i2c();
        rd_addr = {3{4'd6}};
        write_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h0055;
        #1;
        total++; if (i2c_go !== 1'b0) begin bad++; $display("FAIL go_before_edge got=%b exp=0", i2c_go); end
        total++; if (rd_data[15:0] !== 16'h0055) begin bad++; $display("FAIL i2c_bypass got=%h exp=0055", rd_data[15:0]); end
        tick();
        write_en = 1'b0;
        total++; if (i2c_addr !== 9'h055) begin bad++; $display("FAIL i2c_addr got=%h exp=055", i2c_addr); end
        total++; if (i2c_go !== 1'b1) begin bad++; $display("FAIL go_pulse got=%b exp=1", i2c_go); end
        tick();
        total++; if (i2c_go !== 1'b0) begin bad++; $display("FAIL go_single got=%b exp=0", i2c_go); end
        write_en = 1'b1; wr_data = 16'hF1AA;
        tick();
        wr_data = 16'h0055;
        #1;
        total++; if (i2c_go !== 1'b1) begin bad++; $display("FAIL b2b_go1 got=%b exp=1", i2c_go); end
        total++; if (i2c_addr !== 9'h1AA) begin bad++; $display("FAIL b2b_addr1 got=%h exp=1aa", i2c_addr); end
        total++; if (rd_data_nb[15:0] !== 16'h01AA) begin bad++; $display("FAIL i2c_upper_ignored got=%h exp=01aa", rd_data_nb[15:0]); end
        tick();
        write_en = 1'b0;
        total++; if (i2c_go !== 1'b1) begin bad++; $display("FAIL b2b_go2 got=%b exp=1", i2c_go); end
        total++; if (i2c_addr !== 9'h055) begin bad++; $display("FAIL b2b_addr2 got=%h exp=055", i2c_addr); end
        tick();
        total++; if (i2c_go !== 1'b0) begin bad++; $display("FAIL b2b_go_end got=%b exp=0", i2c_go); end
        total++; if (rd_data[15:0] !== 16'h0055) begin bad++; $display("FAIL i2c_read got=%h exp=0055", rd_data[15:0]); end
    endtask

    task automatic test_sticky();
        rd_addr = {3{4'd6}};
        i2c_sts = 2'b10; tick(); i2c_sts = 2'b00;
        total++; if (rd_data[15:0] !== 16'h0455) begin bad++; $display("FAIL sticky_set got=%h exp=0455", rd_data[15:0]); end
        tick();
        total++; if (rd_data[15:0] !== 16'h0455) begin bad++; $display("FAIL sticky_hold got=%h exp=0455", rd_data[15:0]); end
        write_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h0033;
        #1;
        total++; if (rd_data[15:0] !== 16'h0433) begin bad++; $display("FAIL sticky_bypass got=%h exp=0433", rd_data[15:0]); end
        tick();
        wr_data = 16'h0433;
        tick();
        write_en = 1'b0;
        total++; if (rd_data[15:0] !== 16'h0033) begin bad++; $display("FAIL sticky_w1c got=%h exp=0033", rd_data[15:0]); end
        i2c_sts = 2'b10; tick();
        write_en = 1'b1; wr_data = 16'h0433; tick();
        write_en = 1'b0; i2c_sts = 2'b00;
        total++; if (rd_data[15:0] !== 16'h0433) begin bad++; $display("FAIL sticky_set_wins got=%h exp=0433", rd_data[15:0]); end
        i2c_sts = 2'b01; tick(); i2c_sts = 2'b00;
        total++; if (rd_data[15:0] !== 16'h0633) begin bad++; $display("FAIL sticky_both got=%h exp=0633", rd_data[15:0]); end
        write_en = 1'b1; wr_data = 16'h0433; tick();
        write_en = 1'b0;
        total++; if (rd_data[15:0] !== 16'h0233) begin bad++; $display("FAIL sticky_w0_keeps got=%h exp=0233", rd_data[15:0]); end
    endtask

    task automatic test_pwm();
        write_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h0100; tick();
        wr_addr = 4'd15; wr_data = 16'h7FFF; tick();
        write_en = 1'b0;
        total++; if (pwm_out !== 128'h0) begin bad++; $display("FAIL pwm_staged_only got=%h exp=0", pwm_out); end
        rd_addr = {4'd15, 4'd9, 4'd8};
        #1;
        total++; if (rd_data !== {16'h7FFF, 16'h0000, 16'h0100}) begin bad++; $display("FAIL pwm_stage_read got=%h exp=7fff00000100", rd_data); end
        pwm_commit = 1'b1; tick(); pwm_commit = 1'b0;
        total++; if (pwm_out[15:0] !== 16'h0100) begin bad++; $display("FAIL pwm_ch0 got=%h exp=0100", pwm_out[15:0]); end
        total++; if (pwm_out[127:112] !== 16'h7FFF) begin bad++; $display("FAIL pwm_ch7 got=%h exp=7fff", pwm_out[127:112]); end
        total++; if (pwm_out[111:16] !== 96'h0) begin bad++; $display("FAIL pwm_mid got=%h exp=0", pwm_out[111:16]); end
    endtask

    task automatic test_pwm_same_cycle();
        write_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0010; tick();
        wr_data = 16'h0020; pwm_commit = 1'b1; tick();
        write_en = 1'b0; pwm_commit = 1'b0;
        rd_addr = {3{4'd9}};
        #1;
        total++; if (pwm_out[31:16] !== 16'h0010) begin bad++; $display("FAIL pwm_prewrite got=%h exp=0010", pwm_out[31:16]); end
        total++; if (rd_data[31:16] !== 16'h0020) begin bad++; $display("FAIL pwm_stage_new got=%h exp=0020", rd_data[31:16]); end
        pwm_commit = 1'b1; tick(); pwm_commit = 1'b0;
        total++; if (pwm_out[31:16] !== 16'h0020) begin bad++; $display("FAIL pwm_recommit got=%h exp=0020", pwm_out[31:16]); end
        total++; if (pwm_out[15:0] !== 16'h0100) begin bad++; $display("FAIL pwm_ch0_kept got=%h exp=0100", pwm_out[15:0]); end
    endtask

    task automatic test_commit_hold();
        pwm_commit = 1'b1;
        write_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h0ABC; tick();
        write_en = 1'b0;
        total++; if (pwm_out[47:32] !== 16'h0000) begin bad++; $display("FAIL hold_first got=%h exp=0000", pwm_out[47:32]); end
        tick();
        total++; if (pwm_out[47:32] !== 16'h0ABC) begin bad++; $display("FAIL hold_second got=%h exp=0abc", pwm_out[47:32]); end
        write_en = 1'b1; wr_data = 16'h0DEF; tick();
        write_en = 1'b0;
        total++; if (pwm_out[47:32] !== 16'h0ABC) begin bad++; $display("FAIL hold_prewrite got=%h exp=0abc", pwm_out[47:32]); end
        tick();
        total++; if (pwm_out[47:32] !== 16'h0DEF) begin bad++; $display("FAIL hold_third got=%h exp=0def", pwm_out[47:32]); end
        pwm_commit = 1'b0;
    endtask

    task automatic test_reset_late();
        rd_addr = {4'd6, 4'd10, 4'd9};
        #1;
        rst = 1'b0;
        #1;
        total++; if (pwm_out !== 128'h0) begin bad++; $display("FAIL late_rst_pwm got=%h exp=0", pwm_out); end
        total++; if (i2c_addr !== 9'h0) begin bad++; $display("FAIL late_rst_addr got=%h exp=0", i2c_addr); end
        total++; if (rd_data !== 48'h0) begin bad++; $display("FAIL late_rst_rd got=%h exp=0", rd_data); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_r0();
        test_bypass();
        test_i2c();
        test_sticky();
        test_pwm();
        test_pwm_same_cycle();
        test_commit_hold();
        test_reset_late();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synth_reg_file_p.md
Name: synth_reg_file_p

Overview:
Parametrised successor to the synthesizer's 16x16 register file. Provides N-read/1-write general registers with a hardwired-zero register 0. Adds optional write-to-read bypass, sticky I2C status bits with write-1-to-clear, a one-cycle I2C start strobe, and double-buffered PWM channel registers that update atomically on a commit strobe. Sits between the control datapath (register reads and writes) and the I2C and PWM peripherals.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 16, register count including hardwired r0; ADDR_W = clog2(NUM_REGS)
NUM_RD, 3, number of combinational read ports
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
I2C_REG, 6, index of the I2C control/status register
I2C_ADDR_W, 9, width of the I2C address field, in bits [I2C_ADDR_W-1:0]
STS_W, 2, sticky status bits, located at [I2C_ADDR_W+STS_W-1:I2C_ADDR_W]
PWM_BASE, 8, first PWM staging register index
NUM_PWM, 8, number of PWM channels

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-low
write_en  in  1  write strobe
wr_addr  in  ADDR_W  write register index
wr_data  in  DATA_W  write data
rd_addr  in  NUM_RD*ADDR_W  read indices; port k uses slice k
rd_data  out  NUM_RD*DATA_W  read data; port k uses slice k
i2c_sts  in  STS_W  level status from the I2C master
i2c_addr  out  I2C_ADDR_W  I2C target/address field
i2c_go  out  1  one-cycle start pulse
pwm_commit  in  1  copies all PWM staging registers to pwm_out
pwm_out  out  NUM_PWM*DATA_W  active PWM duty values; channel c uses slice c

Behaviour:
- Reset (rst=0, asynchronous): all registers, sticky bits and pwm_out are 0; i2c_go=0; i2c_addr=0. Outputs are held there until the first clock edge after rst deasserts.
- Write: at posedge, if write_en=1 and wr_addr is in 1..NUM_REGS-1, then reg[wr_addr] <= wr_data. wr_addr=0 and out-of-range indices are ignored.
- Read: purely combinational. Index 0 and out-of-range indices return 0.
  - If BYPASS=1, write_en=1 and wr_addr==rd_addr!=0, the port returns wr_data in the same cycle.
  - If BYPASS=0, the port returns the stored value.
  - For I2C_REG, bypass forwards only the software field; sticky bits always show their stored value.
- I2C_REG layout:
  - [I2C_ADDR_W-1:0] is software read/write.
  - Sticky bits: bit j is set at posedge when i2c_sts[j]=1. It is cleared when software writes I2C_REG with a 1 in that bit position. A write of 0 leaves the bit unchanged. If set and clear occur in the same cycle, set wins.
  - All remaining upper bits read 0 and ignore writes.
- i2c_addr is driven directly from the stored field, so it changes on the edge after the write.
- i2c_go is registered: it is 1 for exactly the cycle after any accepted write to I2C_REG, otherwise 0. Back-to-back writes give back-to-back pulses.
- PWM registers:
  - Registers PWM_BASE..PWM_BASE+NUM_PWM-1 are staging registers; reads return the staging value.
  - At posedge with pwm_commit=1, every pwm_out channel c <= staging[PWM_BASE+c], all channels in the same edge.
  - If a write and a commit fall in the same cycle, pwm_out takes the pre-write staging value; the new value lands in staging only.
  - pwm_commit held high re-commits on every edge.
- Legal configuration: 1 <= I2C_REG < NUM_REGS; PWM_BASE >= 1; PWM_BASE+NUM_PWM <= NUM_REGS; I2C_REG outside the PWM range; I2C_ADDR_W+STS_W <= DATA_W. Violations are flagged by elaboration-time assertions.

Decomposition:
- Shared package synth_regs_pkg holds:
  - the default DATA_W;
  - the register index constants REG_I2C=6 and REG_PWM_BASE=8;
  - the field constants I2C_ADDR_LSB=0 and I2C_STS_LSB=9;
  - the function clog2.
- Sub-module reg_rd_port: one read mux with zero and out-of-range handling plus bypass compare. It is instantiated NUM_RD times in a generate loop.

Test Plan:
- Reset/r0: assert rst mid-run after writing r3=0x1234 -> all rd_data=0, pwm_out=0, i2c_go=0 immediately, without waiting for a clock edge. Then write r0=0xFFFF -> reading r0 returns 0.
- Three-port read with bypass: write r5=0xBEEF while all three ports read r5 -> all three return 0xBEEF in the same cycle. With BYPASS=0 they return the old value 0x0000 that cycle and 0xBEEF the next.
- I2C: write I2C_REG=0x0055 -> i2c_addr=0x055 next cycle and i2c_go=1 for exactly one cycle. Write a second time on the very next cycle -> i2c_go is high for 2 consecutive cycles.
- Sticky status: pulse i2c_sts=2'b10 for one cycle -> I2C_REG reads 0x0400 | addr. Write 0x0400|addr -> bit clears. Clear while i2c_sts[1]=1 in the same cycle -> bit stays 1.
- PWM double buffer: write r8=0x0100 and r15=0x7FFF -> pwm_out unchanged (0). Pulse pwm_commit -> ch0=0x0100 and ch7=0x7FFF on the same edge.
- PWM write + commit in the same cycle: r9 holds 0x0010, write r9=0x0020 with pwm_commit=1 -> ch1=0x0010. Next commit -> ch1=0x0020.
